// File: rtl/alu_mc_if.sv
// Request/result bundle for the multi-cycle ALU.
// The CPU control side is the master, and the ALU is the slave.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] hi;
    logic             z;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (output start, op, a, b, input r, hi, z, busy, done, dz);
    modport slave  (input start, op, a, b, output r, hi, z, busy, done, dz);
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus shift-add multiply and restoring divide.
// Define ALU_DIV_EN to compile in the divider; without it, div/divu complete as illegal ops.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     clrn,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
`ifdef ALU_DIV_EN
    localparam logic [1:0] DIV  = 2'd2;
`endif
    localparam logic [1:0] FIX  = 2'd3;

    logic [1:0]       state_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH-1:0] acc_reg, mq_reg, mcand_reg;
    logic             neg_q_reg;
    logic [WIDTH-1:0] r_reg, hi_reg;
    logic             z_reg, done_reg, dz_reg;
`ifdef ALU_DIV_EN
    logic             neg_r_reg, bz_reg, div_reg;
    logic [WIDTH-1:0] a_reg;
`endif

    logic [WIDTH-1:0] sc_r, mag_a, mag_b, acc_next, mq_next, fix_r, fix_hi;
    logic [SHW-1:0]   shamt;
    logic             is_mul, is_div, sgn;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod, prod_s;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;
`endif

    assign shamt  = bus.a[SHW-1:0];
    assign sgn    = ~bus.op[0];
    assign is_mul = bus.op[4] & (bus.op[3:2] == 2'b00) & ~bus.op[1];
`ifdef ALU_DIV_EN
    assign is_div = bus.op[4] & (bus.op[3:2] == 2'b00) & bus.op[1];
`else
    assign is_div = 1'b0;
`endif

    // Signed modes iterate on magnitudes; MIN maps onto itself, which is the right unsigned value.
    assign mag_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    always_comb begin
        sc_r = '0;
        case (bus.op[2:0])
            3'b000: sc_r = bus.a + bus.b;
            3'b100: sc_r = bus.a - bus.b;
            3'b001: sc_r = bus.a & bus.b;
            3'b101: sc_r = bus.a | bus.b;
            3'b010: sc_r = bus.a ^ bus.b;
            3'b110: sc_r = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            3'b011: sc_r = bus.b << shamt;
            3'b111: sc_r = bus.op[3] ? WIDTH'($signed(bus.b) >>> shamt) : (bus.b >> shamt);
            default: sc_r = '0;
        endcase
        if (bus.op[4]) sc_r = '0;
    end

    // One iteration: mq holds multiplier (mul) or dividend/quotient (div), acc the upper half/remainder.
    always_comb begin
        mul_sum  = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, mcand_reg} : '0);
        acc_next = mul_sum[WIDTH:1];
        mq_next  = {mul_sum[0], mq_reg[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_sh   = {acc_reg, mq_reg[WIDTH-1]};
        div_diff = div_sh - {1'b0, mcand_reg};
        div_ge   = ~div_diff[WIDTH];
        if (div_reg) begin
            acc_next = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            mq_next  = {mq_reg[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        prod   = {acc_reg, mq_reg};
        prod_s = neg_q_reg ? -prod : prod;
        fix_r  = prod_s[WIDTH-1:0];
        fix_hi = prod_s[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
        if (div_reg) begin
            if (bz_reg) begin
                fix_r  = '1;
                fix_hi = a_reg;
            end else begin
                fix_r  = neg_q_reg ? -mq_reg : mq_reg;
                fix_hi = neg_r_reg ? -acc_reg : acc_reg;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mq_reg    <= '0;
            mcand_reg <= '0;
            neg_q_reg <= 1'b0;
            r_reg     <= '0;
            hi_reg    <= '0;
            z_reg     <= 1'b1;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
`ifdef ALU_DIV_EN
            neg_r_reg <= 1'b0;
            bz_reg    <= 1'b0;
            div_reg   <= 1'b0;
            a_reg     <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (bus.start) begin
                    if (is_mul || is_div) begin
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                        mq_reg    <= mag_a;
                        mcand_reg <= mag_b;
                        neg_q_reg <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        state_reg <= MUL;
`ifdef ALU_DIV_EN
                        neg_r_reg <= sgn & bus.a[WIDTH-1];
                        bz_reg    <= (bus.b == '0);
                        div_reg   <= is_div;
                        a_reg     <= bus.a;
                        if (is_div) state_reg <= DIV;
`endif
                    end else begin
                        r_reg    <= sc_r;
                        hi_reg   <= '0;
                        z_reg    <= (sc_r == '0);
                        done_reg <= 1'b1;
                    end
                end
`ifdef ALU_DIV_EN
                MUL, DIV: begin
`else
                MUL: begin
`endif
                    acc_reg <= acc_next;
                    mq_reg  <= mq_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) state_reg <= FIX;
                end
                FIX: begin
                    r_reg     <= fix_r;
                    hi_reg    <= fix_hi;
                    z_reg     <= (fix_r == '0);
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
`ifdef ALU_DIV_EN
                    if (div_reg) dz_reg <= bz_reg;
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.r    = r_reg;
    assign bus.hi   = hi_reg;
    assign bus.z    = z_reg;
    assign bus.done = done_reg;
    assign bus.dz   = dz_reg;
    assign bus.busy = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: table of single-cycle vectors plus hand-written iterative/reset sequences.
// Division cases are exercised when ALU_DIV_EN is defined; otherwise div opcodes are checked as illegal.
module tb_alu_mc;
    logic clk  = 1'b0;
    logic clrn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_mc_if #(.WIDTH(32)) bus ();
    alu_mc #(.WIDTH(32)) dut (.clk(clk), .clrn(clrn), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_sc(input vec_t v);
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
        @(negedge clk);
        bus.start = 1'b0;
        chk({v.nm, " done"}, bus.done, 1);
        chk({v.nm, " busy"}, bus.busy, 0);
        chk({v.nm, " r"},    bus.r,    v.r);
        chk({v.nm, " hi"},   bus.hi,   0);
        chk({v.nm, " z"},    bus.z,    v.z);
        chk({v.nm, " dz"},   bus.dz,   0);
        $display("txn %s op=%b a=%h b=%h r=%h hi=%h z=%b", v.nm, v.op, v.a, v.b, bus.r, bus.hi, bus.z);
    endtask

    task automatic run_iter(input string nm, input logic [4:0] o, input logic [31:0] ai, input logic [31:0] bi,
                            input logic [31:0] er, input logic [31:0] eh, input logic edz, input bit inject);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = ai; bus.b = bi;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'h12345678;
        chk({nm, " done early"}, bus.done, 0);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (inject && n == 5) begin
                bus.start = 1'b1; bus.op = 5'b00000; bus.a = 32'd1; bus.b = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({nm, " busy cycles"}, n, 33);
        chk({nm, " done"}, bus.done, 1);
        chk({nm, " r"},    bus.r,    er);
        chk({nm, " hi"},   bus.hi,   eh);
        chk({nm, " z"},    bus.z,    (er == 32'd0));
        chk({nm, " dz"},   bus.dz,   edz);
        $display("txn %s op=%b a=%h b=%h r=%h hi=%h dz=%b cycles=%0d", nm, o, ai, bi, bus.r, bus.hi, bus.dz, n);
        @(negedge clk);
        chk({nm, " done pulse"}, bus.done, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

        vecs.push_back('{"add_wrap", 5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0});
        vecs.push_back('{"sub_zero", 5'b00100, 32'd5,        32'd5,        32'h00000000, 1'b1});
        vecs.push_back('{"lui",      5'b00110, 32'h0,        32'h00001234, 32'h12340000, 1'b0});
        vecs.push_back('{"sra",      5'b01111, 32'd4,        32'hF0000000, 32'hFF000000, 1'b0});
        vecs.push_back('{"srl",      5'b00111, 32'd4,        32'hF0000000, 32'h0F000000, 1'b0});
        vecs.push_back('{"and",      5'b00001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
        vecs.push_back('{"or",       5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0});
        vecs.push_back('{"xor",      5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0});
        vecs.push_back('{"sll",      5'b00011, 32'd4,        32'h0000000F, 32'h000000F0, 1'b0});
        vecs.push_back('{"sll31",    5'b01011, 32'h0000003F, 32'h00000003, 32'h80000000, 1'b0});
        vecs.push_back('{"add_x1",   5'b01000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1});
        vecs.push_back('{"ill_101",  5'b10100, 32'd9,        32'd3,        32'h00000000, 1'b1});
        vecs.push_back('{"ill_11",   5'b11000, 32'd9,        32'd3,        32'h00000000, 1'b1});
`ifndef ALU_DIV_EN
        vecs.push_back('{"nodiv",    5'b10010, 32'd9,        32'd3,        32'h00000000, 1'b1});
        vecs.push_back('{"nodivu",   5'b10011, 32'd9,        32'd3,        32'h00000000, 1'b1});
`endif

        @(negedge clk);
        @(negedge clk);
        chk("rst r",    bus.r,    0);
        chk("rst hi",   bus.hi,   0);
        chk("rst z",    bus.z,    1);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst dz",   bus.dz,   0);
        clrn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply_sc(vecs[i]);

        run_iter("mult", 5'b10000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b1);
`ifdef ALU_DIV_EN
        run_iter("div",     5'b10010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_iter("divu_z",  5'b10011, 32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        1'b1, 1'b0);
        run_iter("div_min", 5'b10010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
`endif

        // Abort a multu mid-iteration; async reset must clear outputs without waiting for a clock.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 5'b10001; bus.a = 32'd5; bus.b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-abort busy", bus.busy, 1);
        #2 clrn = 1'b0;
        #1;
        chk("abort r",    bus.r,    0);
        chk("abort hi",   bus.hi,   0);
        chk("abort z",    bus.z,    1);
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort dz",   bus.dz,   0);
        $display("txn abort_multu reset asserted r=%h hi=%h busy=%b", bus.r, bus.hi, bus.busy);
        @(negedge clk);
        @(negedge clk);
        chk("abort no done", bus.done, 0);
        clrn = 1'b1;
        run_iter("multu_max", 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
